// File: rtl/rv_pkg.sv
// Shared RISC-V datapath types and constants for the integer register file.
// Register index names, address/data typedefs and reset defaults for sp/gp.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t X0 = 5'd0;
  localparam reg_addr_t RA = 5'd1;
  localparam reg_addr_t SP = 5'd2;
  localparam reg_addr_t GP = 5'd3;

  localparam xlen_t SP_INIT_DEFAULT = 32'h0000_0FFC;
  localparam xlen_t GP_INIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: address decode and x0 forcing.
// With REGFILE_WR_BYPASS_EN defined, BYPASS=1 instances forward a same-cycle write.
module rf_read_port
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned NREGS = 32
`ifdef REGFILE_WR_BYPASS_EN
  ,
  parameter bit          BYPASS = 1'b1
`endif
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [REG_AW-1:0]          addr,
`ifdef REGFILE_WR_BYPASS_EN
  input  logic                       we,
  input  logic [REG_AW-1:0]          wa,
  input  logic [XLEN-1:0]            wd,
`endif
  output logic [XLEN-1:0]            rd
);

  always_comb begin
    rd = regs[addr];
`ifdef REGFILE_WR_BYPASS_EN
    if (BYPASS && we && (wa != X0) && (addr == wa)) begin
      rd = wd;
    end
`endif
    // x0 forcing is applied last so nothing, bypass included, can override it
    if (addr == X0) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file_wd3.sv
// RISC-V 32x32 integer register file fed by the WD3-source write-back mux.
// Optional write-first forwarding on rd1/rd2: define REGFILE_WR_BYPASS_EN.
module reg_file_wd3
  import rv_pkg::*;
#(
  parameter int unsigned XLEN    = rv_pkg::XLEN,
  parameter int unsigned NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT,
  parameter logic [XLEN-1:0] GP_INIT = GP_INIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we3,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [4:0]      dbg_a,
  output logic [XLEN-1:0] dbg_rd,
  output logic [15:0]     wr_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[SP] <= SP_INIT;
      regs[GP] <= GP_INIT;
      wr_cnt   <= '0;
    end else if (we3 && (a3 != X0)) begin
      regs[a3] <= wd3;
      wr_cnt   <= wr_cnt + 16'd1;
    end
  end

  rf_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rs1 (
    .regs (regs),
    .addr (a1),
`ifdef REGFILE_WR_BYPASS_EN
    .we   (we3),
    .wa   (a3),
    .wd   (wd3),
`endif
    .rd   (rd1)
  );

  rf_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rs2 (
    .regs (regs),
    .addr (a2),
`ifdef REGFILE_WR_BYPASS_EN
    .we   (we3),
    .wa   (a3),
    .wd   (wd3),
`endif
    .rd   (rd2)
  );

  rf_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS)
`ifdef REGFILE_WR_BYPASS_EN
    ,
    .BYPASS (1'b0)
`endif
  ) u_dbg (
    .regs (regs),
    .addr (dbg_a),
`ifdef REGFILE_WR_BYPASS_EN
    .we   (1'b0),
    .wa   (5'd0),
    .wd   ('0),
`endif
    .rd   (dbg_rd)
  );

endmodule

// File: tb/tb_reg_file_wd3.sv
// Randomized self-checking bench for reg_file_wd3 against an array-based model.
// Expectations follow REGFILE_WR_BYPASS_EN when it is defined for the build.
module tb_reg_file_wd3;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we3;
  logic [4:0]  a1, a2, a3, dbg_a;
  logic [31:0] wd3, rd1, rd2, dbg_rd;
  logic [15:0] wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [32];
  int unsigned cnt;

  reg_file_wd3 #(
    .XLEN    (32),
    .NREGS   (32),
    .SP_INIT (32'h0000_0FFC),
    .GP_INIT (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we3    (we3),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .wd3    (wd3),
    .rd1    (rd1),
    .rd2    (rd2),
    .dbg_a  (dbg_a),
    .dbg_rd (dbg_rd),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[2] = 32'h0000_0FFC;
    mem[3] = 32'h0000_0000;
    cnt = 0;
  endtask

  // Architectural read value given the currently driven write-port inputs
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
    if (a == 5'd0) return 32'h0;
    if (fwd && BYP && we3 && a3 != 5'd0 && a == a3) return wd3;
    return mem[a];
  endfunction

  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] da,
                      input bit chk);
    we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2; dbg_a = da;
    #1;
    if (chk) begin
      check("rd1_pre", rd1, exp_rd(ra1, 1'b1));
      check("rd2_pre", rd2, exp_rd(ra2, 1'b1));
      check("dbg_pre", dbg_rd, exp_rd(da, 1'b0));
    end
    @(posedge clk);
    if (we && wa != 5'd0) begin
      mem[wa] = wd;
      cnt = (cnt + 1) % 65536;
    end
    #1;
    if (chk) begin
      check("rd1_post", rd1, exp_rd(ra1, 1'b1));
      check("dbg_post", dbg_rd, exp_rd(da, 1'b0));
      check("wr_cnt", {16'h0, wr_cnt}, cnt);
    end
  endtask

  initial begin
    logic [4:0]  ra, rb, rw;
    logic [31:0] last;
    rst_n = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; dbg_a = 5'd2;
    last = '0;

    // Reset asserted between edges must take effect at once
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("rst_sp", dbg_rd, 32'h0000_0FFC);
    dbg_a = 5'd5;
    #1 check("rst_x5", dbg_rd, 32'h0);
    check("rst_cnt", {16'h0, wr_cnt}, 32'h0);
    dbg_a = 5'd3; a1 = 5'd2;
    #1 check("rst_gp", dbg_rd, 32'h0);
    check("rst_rd1_sp", rd1, 32'h0000_0FFC);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 5'd5, 1'b1);
    check("wr_x5", rd1, 32'hDEAD_BEEF);
    check("wr_cnt1", {16'h0, wr_cnt}, 32'h1);

    step(1'b1, 5'd0, 32'h1234_5678, 5'd5, 5'd0, 5'd0, 1'b1);
    check("x0_rd2", rd2, 32'h0);
    check("x0_cnt", {16'h0, wr_cnt}, 32'h1);

    // Same-cycle hazard on x7
    step(1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd7, 1'b1);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h2; a1 = 5'd7; a2 = 5'd7; dbg_a = 5'd7;
    #1;
    check("hz_rd1_pre", rd1, BYP ? 32'h2 : 32'h1);
    check("hz_dbg_pre", dbg_rd, 32'h1);
    @(posedge clk); mem[7] = 32'h2; cnt = (cnt + 1) % 65536;
    #1;
    check("hz_rd1_post", rd1, 32'h2);

    for (int k = 0; k < 300; k++) begin
      rw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, rw, $urandom, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
    end

    // Reset lands mid-cycle with a write pending and is held across the edge
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'hAAAA_AAAA; dbg_a = 5'd9;
    #1 rst_n = 1'b0;
    model_reset();
    #1 check("rmw_cnt", {16'h0, wr_cnt}, 32'h0);
    @(posedge clk); #1;
    we3 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rmw_x9", dbg_rd, 32'h0);
    dbg_a = 5'd2;
    #1 check("rmw_sp", dbg_rd, 32'h0000_0FFC);

    // 65536 writes to x1 wrap the counter back to zero
    for (int k = 0; k < 65536; k++) begin
      last = $urandom;
      step(1'b1, 5'd1, last, 5'd1, 5'd0, 5'd1, k >= 65533);
    end
    we3 = 1'b0;
    #1;
    check("wrap_cnt", {16'h0, wr_cnt}, 32'h0);
    check("wrap_x1", dbg_rd, last);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
